// File: rtl/merge2to1_arbiter.sv
// Purpose : merge two 24-bit valid/ready producer channels (A, B) into one
//           registered consumer channel, tagging each word with its source.
// Latency : 1 cycle (word accepted at edge N is presented after edge N).
// Backpressure: a_ready/b_ready drop to 0 while the output stage is full and
//           out_ready=0; at most one producer is granted per cycle.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   a_data/a_valid/a_ready   producer channel A
//   b_data/b_valid/b_ready   producer channel B
//   out_data/out_sel/out_valid/out_ready   merged consumer channel
//                       (out_sel: 0 = word came from A, 1 = from B)
//   cnt_a, cnt_b        wrapping counts of words accepted from A and B
//
// Build option: define MERGE_RR_EN for round-robin tie-breaking; without it
// A has fixed priority on ties and no last-grant state is kept.

module merge2to1_arbiter #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // producer A
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  // producer B
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  // consumer
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  // debug counters
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,    state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  src_t             out_sel_q,  out_sel_d;
  logic [CNT_W-1:0] cnt_a_q,    cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q,    cnt_b_d;

`ifdef MERGE_RR_EN
  // Source of the most recent transfer; reset to B so the first tie goes to A.
  src_t             last_grant_q, last_grant_d;
`endif

  // ---------------------------------------------------------------------------
  // Grant / handshake
  // ---------------------------------------------------------------------------
  logic load;
  logic grant_a;
  logic grant_b;
  logic xfer_a;
  logic xfer_b;
  logic xfer;

  always_comb begin
    // Stage can take a word when it is empty or being drained this cycle.
    load    = (state_q == ST_EMPTY) | out_ready;

    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
`ifdef MERGE_RR_EN
      // Tie: serve the source that did not get the last transfer.
      if (last_grant_q == SRC_B) begin
        grant_a = 1'b1;
      end else begin
        grant_b = 1'b1;
      end
`else
      grant_a = 1'b1;
`endif
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end

    // Grants are mutually exclusive, so the readies are too.
    a_ready = load & grant_a;
    b_ready = load & grant_b;

    xfer_a  = a_valid & a_ready;
    xfer_b  = b_valid & b_ready;
    xfer    = xfer_a | xfer_b;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for the output stage
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (xfer) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        // Drain with a refill stays full; drain alone empties; stall holds.
        if (xfer) begin
          state_d = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for the datapath and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
`ifdef MERGE_RR_EN
    last_grant_d = last_grant_q;
`endif

    // Data and tag only change on a transfer; an emptying drain leaves the
    // last word visible on out_data with out_valid low.
    if (xfer_a) begin
      out_data_d = a_data;
      out_sel_d  = SRC_A;
      cnt_a_d    = cnt_a_q + CNT_W'(1);
`ifdef MERGE_RR_EN
      last_grant_d = SRC_A;
`endif
    end else if (xfer_b) begin
      out_data_d = b_data;
      out_sel_d  = SRC_B;
      cnt_b_d    = cnt_b_q + CNT_W'(1);
`ifdef MERGE_RR_EN
      last_grant_d = SRC_B;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_sel_q  <= SRC_A;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
    end
  end

`ifdef MERGE_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= SRC_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs (all registered except the readies)
  // ---------------------------------------------------------------------------
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = (state_q == ST_FULL);
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_merge2to1_arbiter.sv
// Directed testbench for merge2to1_arbiter: reset, single-source streaming,
// contention, backpressure, drain to empty, counter wrap and mid-stream reset.
// Expectations follow the build option MERGE_RR_EN (round-robin vs fixed).

module tb_merge2to1_arbiter;

  localparam int WIDTH = 24;
  localparam int CNT_W = 16;

`ifdef MERGE_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  int n_cmp;
  int n_bad;

  merge2to1_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_data    = '0;
    b_data    = '0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    a_data    = '0;
    b_data    = '0;
    out_ready = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 24'h000000) begin n_bad++; $display("FAIL reset_out_data: got %h want 000000", out_data); end
    n_cmp++; if (out_sel !== 1'b0) begin n_bad++; $display("FAIL reset_out_sel: got %b want 0", out_sel); end
    n_cmp++; if (cnt_a !== 16'h0000 || cnt_b !== 16'h0000) begin n_bad++; $display("FAIL reset_counters: got %h/%h want 0000/0000", cnt_a, cnt_b); end
    // Empty stage loads regardless of out_ready.
    a_valid = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_empty: got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
    a_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_source();
    logic [WIDTH-1:0] w;
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      w = WIDTH'(i);
      a_valid = 1'b1;
      a_data  = w;
      #1;
      n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL single_a_ready[%0d]: got %b want 1", i, a_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== w || out_sel !== 1'b0) begin
        n_bad++; $display("FAIL single_out[%0d]: got v=%b d=%h s=%b want v=1 d=%h s=0", i, out_valid, out_data, out_sel, w);
      end
    end
    a_valid = 1'b0;
    n_cmp++; if (cnt_a !== 16'd4 || cnt_b !== 16'd0) begin n_bad++; $display("FAIL single_counts: got %0d/%0d want 4/0", cnt_a, cnt_b); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_contention();
    logic             exp_sel;
    logic [WIDTH-1:0] exp_dat;
    int               b_seen;
    do_reset();
    out_ready = 1'b1;
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    a_data    = 24'hAAAAAA;
    b_data    = 24'hBBBBBB;
    b_seen    = 0;
    for (int i = 0; i < 6; i++) begin
      exp_sel = RR_MODE ? ((i % 2) == 1) : 1'b0;
      exp_dat = exp_sel ? 24'hBBBBBB : 24'hAAAAAA;
      #1;
      if (b_ready === 1'b1) b_seen++;
      n_cmp++; if (a_ready !== ~exp_sel || b_ready !== exp_sel) begin
        n_bad++; $display("FAIL contention_ready[%0d]: got a=%b b=%b want a=%b b=%b", i, a_ready, b_ready, ~exp_sel, exp_sel);
      end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== exp_dat) begin
        n_bad++; $display("FAIL contention_out[%0d]: got v=%b s=%b d=%h want v=1 s=%b d=%h", i, out_valid, out_sel, out_data, exp_sel, exp_dat);
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    n_cmp++; if (cnt_a !== (RR_MODE ? 16'd3 : 16'd6) || cnt_b !== (RR_MODE ? 16'd3 : 16'd0)) begin
      n_bad++; $display("FAIL contention_counts: got %0d/%0d want %0d/%0d", cnt_a, cnt_b, RR_MODE ? 3 : 6, RR_MODE ? 3 : 0);
    end
    n_cmp++; if (b_seen != (RR_MODE ? 3 : 0)) begin n_bad++; $display("FAIL contention_b_ready_cycles: got %0d want %0d", b_seen, RR_MODE ? 3 : 0); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1;
    a_valid   = 1'b1;
    a_data    = 24'h123456;
    tick();
    // Stall with both producers waiting.
    out_ready = 1'b0;
    a_data    = 24'h654321;
    b_valid   = 1'b1;
    b_data    = 24'h0F0F0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got a=%b b=%b want 0 0", i, a_ready, b_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 24'h123456 || out_sel !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%b want v=1 d=123456 s=0", i, out_valid, out_data, out_sel);
      end
    end
    // Release: A accepted in the same cycle the held word drains.
    b_valid   = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", a_ready); end
    tick();
    a_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 24'h654321) begin n_bad++; $display("FAIL bp_release_out: got v=%b d=%h want v=1 d=654321", out_valid, out_data); end
    n_cmp++; if (cnt_a !== 16'd2 || cnt_b !== 16'd0) begin n_bad++; $display("FAIL bp_counts: got %0d/%0d want 2/0", cnt_a, cnt_b); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_drain();
    do_reset();
    out_ready = 1'b1;
    b_valid   = 1'b1;
    b_data    = 24'h00BEEF;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL drain_b_ready: got %b want 1", b_ready); end
    tick();
    b_valid = 1'b0;
    b_data  = 24'h111111;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 24'h00BEEF || out_sel !== 1'b1) begin
      n_bad++; $display("FAIL drain_full: got v=%b d=%h s=%b want v=1 d=00beef s=1", out_valid, out_data, out_sel);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 24'h00BEEF || out_sel !== 1'b1) begin
      n_bad++; $display("FAIL drain_empty: got v=%b d=%h s=%b want v=0 d=00beef s=1", out_valid, out_data, out_sel);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || cnt_b !== 16'd1) begin n_bad++; $display("FAIL drain_idle: got v=%b cnt_b=%0d want v=0 cnt_b=1", out_valid, cnt_b); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_counter_wrap();
    do_reset();
    out_ready = 1'b1;
    b_valid   = 1'b1;
    b_data    = 24'h00000B;
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      a_data = WIDTH'(i);
      tick();
    end
    n_cmp++; if (cnt_a !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want ffff", cnt_a); end
    a_data = 24'hC0FFEE;
    tick();
    a_valid = 1'b0;
    n_cmp++; if (cnt_a !== 16'h0000 || cnt_b !== 16'd1) begin n_bad++; $display("FAIL wrap_rollover: got %h/%h want 0000/0001", cnt_a, cnt_b); end
    n_cmp++; if (out_data !== 24'hC0FFEE || out_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_last_word: got v=%b d=%h want v=1 d=c0ffee", out_valid, out_data); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    a_data    = 24'h777777;
    b_data    = 24'h888888;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 24'h777777) begin n_bad++; $display("FAIL midrst_pre: got v=%b d=%h want v=1 d=777777", out_valid, out_data); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 24'h000000 || cnt_a !== 16'd0 || cnt_b !== 16'd0) begin
      n_bad++; $display("FAIL midrst_async: got v=%b d=%h cnt=%0d/%0d want v=0 d=000000 cnt=0/0", out_valid, out_data, cnt_a, cnt_b);
    end
    tick();
    rst = 1'b0;
    #1;
    // Priority restarts with A on a tie.
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_priority: got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_drain();
    test_counter_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
